tetris_line_clearer: RTL and testbench

// - Sequencer that finds full playfield rows in the grid memory, removes them and drops the rows above.
// - Drives port A (addr/data/we) of the dual-port grid RAM.
// - Invoked by the game controller after a piece locks; signals completion on 'cleared'.

---
 rtl/tetris_grid_pkg.sv | 38 +++
 rtl/grid_cell_addr_gen.sv | 45 ++++
 rtl/tetris_line_clearer.sv | 230 +++++++++++++++++++++++
 tb/tb_tetris_line_clearer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tetris_grid_pkg.sv
// Grid geometry, sequencer encodings and the row/col -> RAM address helper
// shared by the line clearer and its address generator.
package tetris_grid_pkg;

  localparam int COLS   = 12;
  localparam int ROWS   = 20;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 8;
  localparam int ROW_W  = $clog2(ROWS);
  localparam int COL_W  = $clog2(COLS);

  localparam logic [DATA_W-1:0] EMPTY_CELL = {DATA_W{1'b0}};
  localparam logic [ROW_W-1:0]  TOP_ROW    = {ROW_W{1'b0}};
  localparam logic [ROW_W-1:0]  BOTTOM_ROW = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0]  FIRST_COL  = COL_W'(1);
  localparam logic [COL_W-1:0]  LAST_COL   = COL_W'(COLS - 2);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SCAN      = 3'd1,
    ST_SHIFT     = 3'd2,
    ST_CLEAR_TOP = 3'd3,
    ST_DONE      = 3'd4
  } state_e;

  // Sub-steps of one cell access: address on the bus, data back, optional write.
  typedef enum logic [1:0] {
    PH_ISSUE  = 2'd0,
    PH_SAMPLE = 2'd1,
    PH_WRITE  = 2'd2
  } phase_e;

  function automatic logic [ADDR_W-1:0] cell_addr(input logic [ROW_W-1:0] row,
                                                  input logic [COL_W-1:0] col);
    return ADDR_W'(row) * ADDR_W'(COLS) + ADDR_W'(col);
  endfunction

endpackage

// File: rtl/grid_cell_addr_gen.sv
// Interior column counter plus row/col -> grid address mapping, with flags for
// the last interior column and the top row.
module grid_cell_addr_gen
  import tetris_grid_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              col_clr_i,
  input  logic              col_inc_i,
  input  logic [ROW_W-1:0]  row_i,
  output logic [COL_W-1:0]  col_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              last_col_o,
  output logic              first_row_o
);

  logic [COL_W-1:0] col_d;
  logic [COL_W-1:0] col_q;

  // Clear wins over increment so a row change always restarts at column 1.
  always_comb begin
    col_d = col_q;
    if (col_clr_i) begin
      col_d = FIRST_COL;
    end else if (col_inc_i) begin
      col_d = col_q + COL_W'(1);
    end else begin
      col_d = col_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q <= FIRST_COL;
    end else begin
      col_q <= col_d;
    end
  end

  assign col_o       = col_q;
  assign addr_o      = cell_addr(row_i, col_q);
  assign last_col_o  = (col_q == LAST_COL);
  assign first_row_o = (row_i == TOP_ROW);

endmodule

// File: rtl/tetris_line_clearer.sv
// Finds full rows in the grid RAM (port A), removes them and drops the rows above.
// Optional LINE_CLEARER_COUNT_EN adds the 'lines' removed-row count output.
module tetris_line_clearer
  import tetris_grid_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] data_in,
  output logic              cleared,
  output logic              we,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data_out
`ifdef LINE_CLEARER_COUNT_EN
  ,
  output logic [4:0]        lines
`endif
);

  state_e            state_q;
  phase_e            phase_q;
  logic [ROW_W-1:0]  r_q;
  logic [ROW_W-1:0]  s_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_out_q;
  logic              we_q;
  logic              cleared_q;
`ifdef LINE_CLEARER_COUNT_EN
  logic [4:0]        lines_q;
`endif

  logic              col_clr_s;
  logic              col_inc_s;
  logic [ROW_W-1:0]  gen_row_s;
  logic [COL_W-1:0]  col_s;
  logic [ADDR_W-1:0] gen_addr_s;
  logic              last_col_s;
  logic              first_row_s;

  grid_cell_addr_gen u_addr_gen (
    .clk         (clk),
    .rst         (rst),
    .col_clr_i   (col_clr_s),
    .col_inc_i   (col_inc_s),
    .row_i       (gen_row_s),
    .col_o       (col_s),
    .addr_o      (gen_addr_s),
    .last_col_o  (last_col_s),
    .first_row_o (first_row_s)
  );

  // Row the address generator works on: destination row while shifting.
  always_comb begin
    case (state_q)
      ST_SHIFT:     gen_row_s = s_q;
      ST_CLEAR_TOP: gen_row_s = TOP_ROW;
      default:      gen_row_s = r_q;
    endcase
  end

  // Column stepping mirrors the points where the FSM finishes with one cell.
  always_comb begin
    col_clr_s = 1'b0;
    col_inc_s = 1'b0;
    case (state_q)
      ST_IDLE: col_clr_s = 1'b1;
      ST_SCAN: begin
        if (phase_q == PH_SAMPLE) begin
          if ((data_in == EMPTY_CELL) || last_col_s) begin
            col_clr_s = 1'b1;
          end else begin
            col_inc_s = 1'b1;
          end
        end else begin
          col_clr_s = 1'b0;
        end
      end
      ST_SHIFT: begin
        if (phase_q == PH_WRITE) begin
          col_clr_s = last_col_s;
          col_inc_s = !last_col_s;
        end else begin
          col_clr_s = 1'b0;
        end
      end
      ST_CLEAR_TOP: begin
        col_clr_s = last_col_s;
        col_inc_s = !last_col_s;
      end
      default: col_clr_s = 1'b1;
    endcase
  end

  // Sequencer: addr is loaded one cycle ahead so each read costs issue + sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      phase_q    <= PH_ISSUE;
      r_q        <= BOTTOM_ROW;
      s_q        <= BOTTOM_ROW;
      addr_q     <= {ADDR_W{1'b0}};
      data_out_q <= EMPTY_CELL;
      we_q       <= 1'b0;
      cleared_q  <= 1'b0;
`ifdef LINE_CLEARER_COUNT_EN
      lines_q    <= 5'd0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          we_q      <= 1'b0;
          cleared_q <= 1'b0;
          if (en) begin
            state_q <= ST_SCAN;
            phase_q <= PH_ISSUE;
            r_q     <= BOTTOM_ROW;
            addr_q  <= cell_addr(BOTTOM_ROW, FIRST_COL);
`ifdef LINE_CLEARER_COUNT_EN
            lines_q <= 5'd0;
`endif
          end else begin
            state_q <= ST_IDLE;
          end
        end

        ST_SCAN: begin
          if (phase_q == PH_ISSUE) begin
            phase_q <= PH_SAMPLE;
          end else if (data_in == EMPTY_CELL) begin
            phase_q <= PH_ISSUE;
            if (first_row_s) begin
              state_q   <= ST_DONE;
              cleared_q <= 1'b1;
            end else begin
              r_q    <= r_q - ROW_W'(1);
              addr_q <= cell_addr(r_q - ROW_W'(1), FIRST_COL);
            end
          end else if (!last_col_s) begin
            phase_q <= PH_ISSUE;
            addr_q  <= cell_addr(r_q, col_s + COL_W'(1));
          end else begin
            phase_q <= PH_ISSUE;
`ifdef LINE_CLEARER_COUNT_EN
            lines_q <= lines_q + 5'd1;
`endif
            if (first_row_s) begin
              state_q    <= ST_CLEAR_TOP;
              addr_q     <= cell_addr(TOP_ROW, FIRST_COL);
              data_out_q <= EMPTY_CELL;
              we_q       <= 1'b1;
            end else begin
              state_q <= ST_SHIFT;
              s_q     <= r_q;
              addr_q  <= cell_addr(r_q - ROW_W'(1), FIRST_COL);
            end
          end
        end

        ST_SHIFT: begin
          case (phase_q)
            PH_ISSUE: phase_q <= PH_SAMPLE;
            PH_SAMPLE: begin
              addr_q     <= gen_addr_s;
              data_out_q <= data_in;
              we_q       <= 1'b1;
              phase_q    <= PH_WRITE;
            end
            PH_WRITE: begin
              phase_q <= PH_ISSUE;
              if (!last_col_s) begin
                we_q   <= 1'b0;
                addr_q <= cell_addr(s_q - ROW_W'(1), col_s + COL_W'(1));
              end else if (s_q == ROW_W'(1)) begin
                // Row 1 was the last destination; the top row is blanked next.
                s_q        <= TOP_ROW;
                state_q    <= ST_CLEAR_TOP;
                addr_q     <= cell_addr(TOP_ROW, FIRST_COL);
                data_out_q <= EMPTY_CELL;
                we_q       <= 1'b1;
              end else begin
                we_q   <= 1'b0;
                s_q    <= s_q - ROW_W'(1);
                addr_q <= cell_addr(s_q - ROW_W'(2), FIRST_COL);
              end
            end
            default: phase_q <= PH_ISSUE;
          endcase
        end

        ST_CLEAR_TOP: begin
          if (!last_col_s) begin
            addr_q <= cell_addr(TOP_ROW, col_s + COL_W'(1));
          end else begin
            // Rescan the same row: whatever dropped into it may be full too.
            we_q    <= 1'b0;
            state_q <= ST_SCAN;
            phase_q <= PH_ISSUE;
            addr_q  <= cell_addr(r_q, FIRST_COL);
          end
        end

        ST_DONE: begin
          we_q <= 1'b0;
          if (!en) begin
            state_q   <= ST_IDLE;
            cleared_q <= 1'b0;
          end else begin
            cleared_q <= 1'b1;
          end
        end

        default: begin
          state_q   <= ST_IDLE;
          phase_q   <= PH_ISSUE;
          we_q      <= 1'b0;
          cleared_q <= 1'b0;
        end
      endcase
    end
  end

  assign cleared  = cleared_q;
  assign we       = we_q;
  assign addr     = addr_q;
  assign data_out = data_out_q;
`ifdef LINE_CLEARER_COUNT_EN
  assign lines    = lines_q;
`endif

endmodule

// File: tb/tb_tetris_line_clearer.sv
// Self-checking bench: grid RAM model, directed scenarios and random grids
// checked against a row-filtering reference of the line-clear rules.
module tb_tetris_line_clearer;
  import tetris_grid_pkg::*;

  localparam int NCELL = ROWS * COLS;
  localparam int NINT  = COLS - 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] data_in;
  logic       cleared;
  logic       we;
  logic [7:0] addr;
  logic [7:0] data_out;
`ifdef LINE_CLEARER_COUNT_EN
  logic [4:0] lines;
`endif

  always #5 clk = ~clk;

  tetris_line_clearer dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .data_in  (data_in),
    .cleared  (cleared),
    .we       (we),
    .addr     (addr),
    .data_out (data_out)
`ifdef LINE_CLEARER_COUNT_EN
    ,
    .lines    (lines)
`endif
  );

  logic [7:0] mem   [NCELL];
  logic [7:0] img   [NCELL];
  logic [7:0] exp_g [NCELL];
  logic       load_req = 1'b0;
  int         wr_cnt = 0;
  int         bad_acc = 0;
  int         exp_lines;
  int         exp_writes;
  int         n_checks = 0;
  int         n_fail = 0;

  // Grid RAM port A: 1-cycle read latency, write on we; also polices addresses.
  always @(posedge clk) begin
    if (load_req) begin
      for (int i = 0; i < NCELL; i++) mem[i] <= img[i];
    end else if (we) begin
      if (int'(addr) < NCELL) mem[addr] <= data_out;
      wr_cnt <= wr_cnt + 1;
      if (int'(addr) >= NCELL || (int'(addr) % COLS) == 0 || (int'(addr) % COLS) == COLS - 1)
        bad_acc <= bad_acc + 1;
    end else if (int'(addr) >= NCELL) begin
      bad_acc <= bad_acc + 1;
    end
    data_in <= (int'(addr) < NCELL) ? mem[addr] : 8'h00;
  end

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_img(input logic [7:0] wall);
    for (int i = 0; i < NCELL; i++)
      img[i] = ((i % COLS) == 0 || (i % COLS) == COLS - 1) ? wall : 8'h00;
  endtask

  task automatic load_grid();
    @(negedge clk) load_req = 1'b1;
    @(negedge clk) load_req = 1'b0;
  endtask

  // Reference: full rows vanish, surviving rows keep their order at the bottom.
  task automatic model();
    bit full [ROWS];
    int below;
    int dst;
    exp_lines  = 0;
    exp_writes = 0;
    for (int r = 0; r < ROWS; r++) begin
      full[r] = 1'b1;
      for (int c = 1; c <= NINT; c++) if (img[r*COLS+c] == 8'h00) full[r] = 1'b0;
    end
    below = 0;
    for (int r = ROWS - 1; r >= 0; r--) begin
      if (full[r]) begin
        exp_writes += (r + below + 1) * NINT;
        exp_lines++;
        below++;
      end
    end
    for (int i = 0; i < NCELL; i++) exp_g[i] = img[i];
    dst = ROWS - 1;
    for (int r = ROWS - 1; r >= 0; r--) begin
      if (!full[r]) begin
        for (int c = 1; c <= NINT; c++) exp_g[dst*COLS+c] = img[r*COLS+c];
        dst--;
      end
    end
    for (int r = dst; r >= 0; r--)
      for (int c = 1; c <= NINT; c++) exp_g[r*COLS+c] = 8'h00;
  endtask

  task automatic run_op(input string name);
    int base;
    int n;
    logic [127:0] got_row;
    logic [127:0] exp_row;
    model();
    load_grid();
    base = wr_cnt;
    en = 1'b1;
    n = 0;
    while (!cleared && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check_eq({name, "_cleared"}, 128'(cleared), 128'(1));
    check_eq({name, "_writes"}, 128'(wr_cnt - base), 128'(exp_writes));
`ifdef LINE_CLEARER_COUNT_EN
    check_eq({name, "_lines"}, 128'(lines), 128'(exp_lines));
`endif
    for (int r = 0; r < ROWS; r++) begin
      got_row = '0;
      exp_row = '0;
      for (int c = 0; c < COLS; c++) begin
        got_row[c*8 +: 8] = mem[r*COLS+c];
        exp_row[c*8 +: 8] = exp_g[r*COLS+c];
      end
      check_eq($sformatf("%s_row%0d", name, r), got_row, exp_row);
    end
    en = 1'b0;
    @(negedge clk);
    check_eq({name, "_release"}, 128'(cleared), 128'(0));
  endtask

  task automatic make_random();
    bit full;
    for (int r = 0; r < ROWS; r++) begin
      full = ($urandom_range(0, 3) == 0);
      for (int c = 0; c < COLS; c++) begin
        if (c == 0 || c == COLS - 1 || full)
          img[r*COLS+c] = 8'($urandom_range(1, 255));
        else
          img[r*COLS+c] = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      end
      if (!full) img[r*COLS + $urandom_range(1, NINT)] = 8'h00;
    end
  endtask

  initial begin
    int base;
    int n;
    rst = 1'b1;
    en  = 1'b0;
    @(negedge clk);
    check_eq("rst_cleared", 128'(cleared), 128'(0));
    check_eq("rst_we", 128'(we), 128'(0));
    check_eq("rst_addr", 128'(addr), 128'(0));
    rst = 1'b0;
    base = wr_cnt;
    repeat (100) @(negedge clk);
    check_eq("idle_no_writes", 128'(wr_cnt - base), 128'(0));

    clear_img(8'h00);
    run_op("empty");

    clear_img(8'h77);
    for (int i = 229; i <= 238; i++) img[i] = 8'd6;
    img[224] = 8'd4;
    img[220] = 8'd3;
    run_op("single");
    check_eq("single_236", 128'(mem[236]), 128'(4));
    check_eq("single_232", 128'(mem[232]), 128'(3));

    clear_img(8'h55);
    for (int i = 229; i <= 238; i++) img[i] = 8'd6;
    for (int i = 205; i <= 214; i++) img[i] = 8'd1;
    img[224] = 8'd4;
    img[220] = 8'd3;
    run_op("two_sep");
    check_eq("two_sep_236", 128'(mem[236]), 128'(4));

    clear_img(8'h11);
    for (int i = 217; i <= 226; i++) img[i] = 8'd2;
    for (int i = 229; i <= 238; i++) img[i] = 8'd7;
    img[200] = 8'd5;
    run_op("adjacent");
    check_eq("adjacent_224", 128'(mem[224]), 128'(5));

    clear_img(8'h22);
    for (int i = 1; i <= NINT; i++) img[i] = 8'd9;
    run_op("row0");

    clear_img(8'h33);
    for (int r = 0; r < ROWS; r++)
      for (int c = 1; c <= NINT; c++) img[r*COLS+c] = 8'($urandom_range(1, 255));
    run_op("fullgrid");

    for (int t = 0; t < 10; t++) begin
      make_random();
      run_op($sformatf("rand%0d", t));
    end

    // Reset while the bottom row is being refilled from the row above.
    clear_img(8'h44);
    for (int i = 229; i <= 238; i++) img[i] = 8'd6;
    img[224] = 8'd4;
    load_grid();
    en = 1'b1;
    n = 0;
    while (!we && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check_eq("midshift_reached", 128'(we), 128'(1));
    rst = 1'b1;
    en  = 1'b0;
    @(posedge clk);
    #1;
    check_eq("midshift_we", 128'(we), 128'(0));
    check_eq("midshift_cleared", 128'(cleared), 128'(0));
    check_eq("midshift_addr", 128'(addr), 128'(0));
    rst = 1'b0;
    base = wr_cnt;
    repeat (40) @(negedge clk);
    check_eq("midshift_idle", 128'(wr_cnt - base), 128'(0));

    check_eq("addr_policing", 128'(bad_acc), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
